// File: rtl/dtw_batch_sched_if.sv
// DTW core control/result bundle between the batch scheduler (master) and one DTW core (slave).
interface dtw_batch_sched_if #(
  parameter int unsigned AXI_DWIDTH = 32
) ();
  logic                  core_rst;
  logic                  core_running;
  logic                  core_mode;
  logic                  core_done;
  logic [AXI_DWIDTH-1:0] core_minval;
  logic [AXI_DWIDTH-1:0] core_pos;

  modport master (
    output core_rst,
    output core_running,
    output core_mode,
    input  core_done,
    input  core_minval,
    input  core_pos
  );

  modport slave (
    input  core_rst,
    input  core_running,
    input  core_mode,
    output core_done,
    output core_minval,
    output core_pos
  );
endinterface

// File: rtl/dtw_batch_sched.sv
// Runs a batch of DTW queries on one core: reset, run, capture each result and track the best.
module dtw_batch_sched #(
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic                  cfg_mode,
  input  logic [15:0]           cfg_batch_len,
  input  logic [31:0]           cfg_timeout,
  dtw_batch_sched_if.master     core,
  output logic                  busy,
  output logic                  batch_done,
  output logic                  err_timeout,
  output logic [15:0]           q_count,
  output logic [AXI_DWIDTH-1:0] best_minval,
  output logic [AXI_DWIDTH-1:0] best_pos,
  output logic [15:0]           best_idx,
  output logic                  irq
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StCrst, StRun, StCapt, StFin} state_e;

  state_e                state_q, state_d;
  logic [RcW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [31:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  mode_q, mode_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           timeout_q, timeout_d;
  logic [15:0]           q_count_q, q_count_d;
  logic [AXI_DWIDTH-1:0] best_minval_q, best_minval_d;
  logic [AXI_DWIDTH-1:0] best_pos_q, best_pos_d;
  logic [15:0]           best_idx_q, best_idx_d;
  logic                  batch_done_q, batch_done_d;
  logic                  err_timeout_q, err_timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      mode_q        <= 1'b0;
      len_q         <= '0;
      timeout_q     <= '0;
      q_count_q     <= '0;
      best_minval_q <= '1;
      best_pos_q    <= '0;
      best_idx_q    <= '0;
      batch_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      timeout_q     <= timeout_d;
      q_count_q     <= q_count_d;
      best_minval_q <= best_minval_d;
      best_pos_q    <= best_pos_d;
      best_idx_q    <= best_idx_d;
      batch_done_q  <= batch_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    mode_d        = mode_q;
    len_d         = len_q;
    timeout_d     = timeout_q;
    q_count_d     = q_count_q;
    best_minval_d = best_minval_q;
    best_pos_d    = best_pos_q;
    best_idx_d    = best_idx_q;
    batch_done_d  = batch_done_q;
    err_timeout_d = err_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (cfg_start && (cfg_batch_len != 16'd0)) begin
          mode_d        = cfg_mode;
          len_d         = cfg_batch_len;
          timeout_d     = cfg_timeout;
          q_count_d     = '0;
          best_minval_d = '1;
          best_pos_d    = '0;
          best_idx_d    = '0;
          batch_done_d  = 1'b0;
          err_timeout_d = 1'b0;
          rst_cnt_d     = '0;
          state_d       = StCrst;
        end
      end
      StCrst: begin
        if (cfg_abort) begin
          state_d = StFin;
        end else if (rst_cnt_q == RcW'(RST_CYCLES - 1)) begin
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        // tmo_cnt_d counts RUN cycles including the current one
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (cfg_abort) begin
          state_d = StFin;
        end else if (core.core_done) begin
          state_d = StCapt;
        end else if ((timeout_q != 32'd0) && (tmo_cnt_d == timeout_q)) begin
          err_timeout_d = 1'b1;
          state_d       = StFin;
        end
      end
      StCapt: begin
        if (cfg_abort) begin
          state_d = StFin;
        end else begin
          // Strict compare: a tie keeps the earlier query
          if ((q_count_q == 16'd0) || (core.core_minval < best_minval_q)) begin
            best_minval_d = core.core_minval;
            best_pos_d    = core.core_pos;
            best_idx_d    = q_count_q;
          end
          q_count_d = q_count_q + 16'd1;
          rst_cnt_d = '0;
          if (q_count_d == len_q) begin
            batch_done_d = 1'b1;
            state_d      = StFin;
          end else begin
            state_d = StCrst;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign core.core_rst     = (state_q == StIdle) || (state_q == StCrst) || (state_q == StFin);
  assign core.core_running = (state_q == StRun);
  assign core.core_mode    = mode_q;

  assign busy        = (state_q == StCrst) || (state_q == StRun) || (state_q == StCapt);
  assign irq         = (state_q == StFin);
  assign batch_done  = batch_done_q;
  assign err_timeout = err_timeout_q;
  assign q_count     = q_count_q;
  assign best_minval = best_minval_q;
  assign best_pos    = best_pos_q;
  assign best_idx    = best_idx_q;

endmodule

// File: tb/tb_dtw_batch_sched.sv
// Directed bench for dtw_batch_sched: table of complete batches plus hand-written corner sequences.
module tb_dtw_batch_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, cfg_abort, cfg_mode;
  logic [15:0] cfg_batch_len;
  logic [31:0] cfg_timeout;
  logic        busy, batch_done, err_timeout, irq;
  logic [15:0] q_count, best_idx;
  logic [31:0] best_minval, best_pos;

  int n_tests = 0;
  int n_fail  = 0;
  int irq_cnt = 0;
  int crst_run = 0;
  int bad_crst = 0;
  int overlap = 0;

  dtw_batch_sched_if #(.AXI_DWIDTH(32)) core_bus ();

  dtw_batch_sched #(.AXI_DWIDTH(32), .RST_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_mode     (cfg_mode),
    .cfg_batch_len(cfg_batch_len),
    .cfg_timeout  (cfg_timeout),
    .core         (core_bus),
    .busy         (busy),
    .batch_done   (batch_done),
    .err_timeout  (err_timeout),
    .q_count      (q_count),
    .best_minval  (best_minval),
    .best_pos     (best_pos),
    .best_idx     (best_idx),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  // Watch core_rst run lengths while busy, core_rst/core_running overlap and irq pulses.
  always @(negedge clk) begin
    if (core_bus.core_rst === 1'b1 && core_bus.core_running === 1'b1) overlap <= overlap + 1;
    if (busy === 1'b1 && core_bus.core_rst === 1'b1) begin
      crst_run <= crst_run + 1;
    end else begin
      if (crst_run != 0 && crst_run != 4) bad_crst <= bad_crst + 1;
      crst_run <= 0;
    end
    if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
  end

  typedef struct {
    logic             mode;
    logic [15:0]      len;
    logic [31:0]      tmo;
    logic [2:0][31:0] mv;
    logic [2:0][31:0] ps;
    logic [2:0][7:0]  dly;
    logic [31:0]      e_minval;
    logic [31:0]      e_pos;
    logic [15:0]      e_idx;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(logic mode, logic [15:0] len, logic [31:0] tmo,
                              logic [31:0] m0, logic [31:0] m1, logic [31:0] m2,
                              logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                              logic [7:0] d0, logic [7:0] d1, logic [7:0] d2,
                              logic [31:0] emv, logic [31:0] epos, logic [15:0] eidx);
    vec_t v;
    v.mode = mode; v.len = len; v.tmo = tmo;
    v.mv[0] = m0; v.mv[1] = m1; v.mv[2] = m2;
    v.ps[0] = p0; v.ps[1] = p1; v.ps[2] = p2;
    v.dly[0] = d0; v.dly[1] = d1; v.dly[2] = d2;
    v.e_minval = emv; v.e_pos = epos; v.e_idx = eidx;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_core_rst"}, core_bus.core_rst, 1);
    chk({nm, "_core_running"}, core_bus.core_running, 0);
    chk({nm, "_core_mode"}, core_bus.core_mode, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_batch_done"}, batch_done, 0);
    chk({nm, "_err_timeout"}, err_timeout, 0);
    chk({nm, "_irq"}, irq, 0);
    chk({nm, "_q_count"}, q_count, 0);
    chk({nm, "_best_minval"}, best_minval, 64'hFFFF_FFFF);
    chk({nm, "_best_pos"}, best_pos, 0);
    chk({nm, "_best_idx"}, best_idx, 0);
  endtask

  task automatic wait_running(input string nm);
    int n = 0;
    while (core_bus.core_running !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_wait_running"}, core_bus.core_running, 1);
  endtask

  task automatic start(input logic mode, input logic [15:0] len, input logic [31:0] tmo);
    cfg_mode = mode; cfg_batch_len = len; cfg_timeout = tmo;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic done_pulse(input logic [31:0] mv, input logic [31:0] ps);
    core_bus.core_done = 1'b1; core_bus.core_minval = mv; core_bus.core_pos = ps;
    tick();
    core_bus.core_done = 1'b0;
  endtask

  task automatic run_batch(input vec_t v, input string nm);
    int irq0;
    irq0 = irq_cnt;
    start(v.mode, v.len, v.tmo);
    chk({nm, "_busy_start"}, busy, 1);
    chk({nm, "_crst_start"}, core_bus.core_rst, 1);
    chk({nm, "_qc_cleared"}, q_count, 0);
    for (int q = 0; q < int'(v.len); q++) begin
      wait_running(nm);
      repeat (int'(v.dly[q])) tick();
      done_pulse(v.mv[q], v.ps[q]);
      chk({nm, "_capt_not_running"}, core_bus.core_running, 0);
      chk({nm, "_capt_no_rst"}, core_bus.core_rst, 0);
      tick();
      if (q < int'(v.len) - 1) chk({nm, "_next_crst"}, core_bus.core_rst, 1);
      else chk({nm, "_fin_irq"}, irq, 1);
    end
    tick();
    chk({nm, "_best_minval"}, best_minval, v.e_minval);
    chk({nm, "_best_pos"}, best_pos, v.e_pos);
    chk({nm, "_best_idx"}, best_idx, v.e_idx);
    chk({nm, "_q_count"}, q_count, v.len);
    chk({nm, "_batch_done"}, batch_done, 1);
    chk({nm, "_err_timeout"}, err_timeout, 0);
    chk({nm, "_core_mode"}, core_bus.core_mode, v.mode);
    chk({nm, "_irq_pulses"}, irq_cnt - irq0, 1);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_core_rst"}, core_bus.core_rst, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int irq0;
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_mode = 1'b0;
    cfg_batch_len = '0; cfg_timeout = '0;
    core_bus.core_done = 1'b0; core_bus.core_minval = '0; core_bus.core_pos = '0;

    vecs[0] = mk(1'b1, 16'd3, 32'd0, 32'd50, 32'd20, 32'd20, 32'd7, 32'd9, 32'd11,
                 8'd2, 8'd0, 8'd5, 32'd20, 32'd9, 16'd1);
    vecs[1] = mk(1'b0, 16'd1, 32'd0, 32'd5, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0,
                 8'd0, 8'd0, 8'd0, 32'd5, 32'd3, 16'd0);
    vecs[2] = mk(1'b0, 16'd3, 32'd100, 32'd30, 32'd40, 32'd10, 32'd1, 32'd2, 32'd3,
                 8'd1, 8'd1, 8'd1, 32'd10, 32'd3, 16'd2);
    // All-ones results: the first query still latches, the tie keeps query 0
    vecs[3] = mk(1'b1, 16'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'd5, 32'd0,
                 8'd0, 8'd3, 8'd0, 32'hFFFF_FFFF, 32'd4, 16'd0);
    // core_done lands on the 3rd RUN cycle, the same cycle the timeout of 3 fires
    vecs[4] = mk(1'b0, 16'd1, 32'd3, 32'd8, 32'd0, 32'd0, 32'd6, 32'd0, 32'd0,
                 8'd2, 8'd0, 8'd0, 32'd8, 32'd6, 16'd0);

    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Zero-length start is ignored
    start(1'b1, 16'd0, 32'd0);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_busy_later", busy, 0);
    chk("len0_core_rst", core_bus.core_rst, 1);
    chk("len0_mode", core_bus.core_mode, 0);

    for (int i = 0; i < 5; i++) run_batch(vecs[i], $sformatf("vec%0d", i));

    // Timeout of 10 with no core_done
    irq0 = irq_cnt;
    start(1'b0, 16'd2, 32'd10);
    wait_running("tmo");
    n = 0;
    while (core_bus.core_running === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("tmo_run_cycles", n, 10);
    chk("tmo_irq", irq, 1);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_batch_done", batch_done, 0);
    chk("tmo_q_count", q_count, 0);
    chk("tmo_busy", busy, 0);
    tick();
    chk("tmo_err_sticky", err_timeout, 1);
    chk("tmo_irq_pulses", irq_cnt - irq0, 1);

    // Abort and core_done in the same RUN cycle
    start(1'b1, 16'd2, 32'd0);
    chk("abort_err_cleared", err_timeout, 0);
    wait_running("abort");
    done_pulse(32'd12, 32'd1);
    tick();
    wait_running("abort");
    cfg_abort = 1'b1;
    done_pulse(32'd3, 32'd2);
    cfg_abort = 1'b0;
    chk("abort_irq", irq, 1);
    chk("abort_busy", busy, 0);
    chk("abort_q_count", q_count, 1);
    chk("abort_batch_done", batch_done, 0);
    chk("abort_best_minval", best_minval, 12);
    chk("abort_best_pos", best_pos, 1);
    tick();

    // Start during RUN is ignored
    start(1'b0, 16'd2, 32'd0);
    wait_running("restart");
    done_pulse(32'd7, 32'd2);
    tick();
    wait_running("restart");
    cfg_batch_len = 16'd5;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("restart_q_count", q_count, 1);
    chk("restart_busy", busy, 1);
    done_pulse(32'd9, 32'd4);
    tick();
    chk("restart_fin_irq", irq, 1);
    chk("restart_batch_done", batch_done, 1);
    chk("restart_q_count_end", q_count, 2);
    tick();

    // Abort in IDLE has no effect
    irq0 = irq_cnt;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    tick();
    chk("idle_abort_batch_done", batch_done, 1);
    chk("idle_abort_irq", irq_cnt - irq0, 0);
    chk("idle_abort_busy", busy, 0);

    // Reset mid-RUN of the second query, then a normal len=1 batch
    start(1'b1, 16'd3, 32'd0);
    wait_running("midrst");
    done_pulse(32'd15, 32'd5);
    tick();
    wait_running("midrst");
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    tick();
    run_batch(mk(1'b0, 16'd1, 32'd0, 32'd33, 32'd0, 32'd0, 32'd44, 32'd0, 32'd0,
                 8'd1, 8'd0, 8'd0, 32'd33, 32'd44, 16'd0), "post_rst");

    tick();
    chk("crst_length_4", bad_crst, 0);
    chk("rst_running_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtw_batch_sched.md
DTW_BATCH_SCHED -- requirements
Module: dtw_batch_sched

Interface
REQ-001 SHALL have parameter AXI_DWIDTH, default 32: width of core result buses and best-result outputs.
REQ-002 SHALL have parameter RST_CYCLES, default 4: number of cycles core_rst is held per query.
REQ-003 SHALL have the following ports; one clock; reset is synchronous and active-high.
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- cfg_start  in  1  one-cycle batch start pulse.
- cfg_abort  in  1  one-cycle abort pulse.
- cfg_mode  in  1  core op mode, latched at start.
- cfg_batch_len  in  16  queries per batch, latched at start.
- cfg_timeout  in  32  max RUN cycles per query, latched at start; 0 disables the timeout.
- core_rst  out  1  DTW core reset.
- core_running  out  1  DTW core start/run.
- core_mode  out  1  DTW core mode.
- core_done  in  1  DTW core done level.
- core_minval  in  AXI_DWIDTH  core min value.
- core_pos  in  AXI_DWIDTH  core position.
- busy  out  1  batch in progress.
- batch_done  out  1  sticky; batch completed.
- err_timeout  out  1  sticky; query timed out.
- q_count  out  16  queries completed in the current batch.
- best_minval  out  AXI_DWIDTH  smallest minval in the batch.
- best_pos  out  AXI_DWIDTH  position for best_minval.
- best_idx  out  16  query index (0-based) of best_minval.
- irq  out  1  one-cycle pulse on completion, timeout or abort.

Function
REQ-004 FSM states SHALL be IDLE, CRST, RUN, CAPT, FIN.
REQ-005 In IDLE, cfg_start with cfg_batch_len!=0 SHALL latch mode/len/timeout, clear q_count, batch_done, err_timeout and the best registers, and go to CRST next cycle.
REQ-006 cfg_start with cfg_batch_len==0 SHALL be ignored. cfg_start outside IDLE SHALL be ignored.
REQ-007 CRST SHALL assert core_rst for exactly RST_CYCLES cycles with core_running=0, then go to RUN.
REQ-008 RUN SHALL hold core_running=1 and core_rst=0, and increment a 32-bit timeout counter each cycle.
- On core_done=1, go to CAPT.
- When the counter equals the latched timeout (timeout!=0), go to FIN with err_timeout set.
REQ-009 If core_done and timeout occur in the same cycle, done SHALL win.
REQ-010 CAPT lasts 1 cycle, with core_running=0.
- Latch core_minval/core_pos into best when q_count==0 or core_minval < best_minval (unsigned, strict); ties keep the earlier query.
- best_idx <= q_count; q_count increments.
- If the new q_count equals batch_len, go to FIN with batch_done set; else go to CRST.
REQ-011 FIN lasts 1 cycle: core_rst=1, irq=1, then IDLE.
REQ-012 busy SHALL be 1 in CRST, RUN and CAPT, and 0 in IDLE and FIN.
REQ-013 cfg_abort in CRST, RUN or CAPT SHALL go to FIN with batch_done=0 and err_timeout unchanged; best/q_count keep their partial values.
- Abort SHALL take priority over done and timeout in the same cycle.
- cfg_abort in IDLE or FIN SHALL have no effect.
REQ-014 core_mode SHALL equal the latched mode at all times after the first start.
REQ-015 Latency: start to first core_rst = 1 cycle; core_done to next core_rst (non-final query) = 2 cycles.

Reset
REQ-016 rst SHALL force IDLE regardless of state, including mid-batch.
- Reset values: core_rst=1, core_running=0, core_mode=0, busy=0, batch_done=0, err_timeout=0, irq=0, q_count=0, best_minval=all ones, best_pos=0, best_idx=0, counters=0.
- core_rst SHALL stay 1 in IDLE.

Verification
REQ-017 Batch of 3 (mode=1, timeout=0), core returns minval 50, 20, 20 with pos 7, 9, 11 -> best_minval=20, best_pos=9, best_idx=1, q_count=3, batch_done=1, one irq pulse, core_mode=1.
REQ-018 timeout=10, core_done never asserted -> FIN entered on the 10th RUN cycle, err_timeout=1, batch_done=0, q_count=0, irq pulse.
REQ-019 core_done and cfg_abort in the same RUN cycle -> abort wins: no CAPT, q_count unchanged, batch_done=0; core_done and timeout in the same cycle -> CAPT taken, err_timeout=0.
REQ-020 cfg_batch_len=0 with cfg_start -> stays IDLE, busy=0; cfg_start during RUN -> ignored, q_count not cleared.
REQ-021 rst asserted mid-RUN of the 2nd query -> next cycle all outputs at reset values; a subsequent start of len=1 completes normally.
REQ-022 Core reset length check: core_rst high for exactly 4 cycles per query with RST_CYCLES=4; core_running never high while core_rst is high.
